regfile_debug_port: RTL and testbench

Debug/bring-up master for the core's 32 x 64-bit register file. It sits between an external debug stream and the register file's read/write ports. It can dump every architectural register out over a valid/ready stream, or load registers x1..x31 from an input stream. While the block is busy, the core's pipeline is stalled and the register-file port mux selects this block.

---
 rtl/regfile_debug_port.sv | 149 ++++++++++++++
 tb/tb_regfile_debug_port.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_debug_port.sv
// Debug master for the core register file: dumps all registers over an output
// stream or loads x1..x31 from an input stream, stalling the core while busy.
module regfile_debug_port #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start_dump,
    input  logic              i_start_load,
    output logic              o_busy,
    output logic              o_done,
    output logic [4:0]        o_rf_addr,
    input  logic [DATA_W-1:0] i_rf_rdata,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_rf_we,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [4:0]        o_out_idx,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data
);

    localparam int unsigned IDX_W = 5;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] FIRST_LD  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMP_RD,
        S_DUMP_OUT,
        S_LOAD,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_next_idx;
    logic [DATA_W-1:0]  r_out_data;
    logic [DATA_W-1:0]  w_next_out_data;
    logic [IDX_W-1:0]   r_out_idx;
    logic [IDX_W-1:0]   w_next_out_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               w_last;

    assign w_last = (r_idx == LAST_IDX);

    // State, index, dump word and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_idx       <= w_next_idx;
            r_out_data  <= w_next_out_data;
            r_out_idx   <= w_next_out_idx;
            r_busy      <= (w_next_state != S_IDLE);
            r_done      <= (w_next_state == S_DONE);
            r_out_valid <= (w_next_state == S_DUMP_OUT);
            r_in_ready  <= (w_next_state == S_LOAD);
        end
    end

    // Next-state logic and the register-file port drive.
    always_comb begin
        w_next_state    = r_state;
        w_next_idx      = r_idx;
        w_next_out_data = r_out_data;
        w_next_out_idx  = r_out_idx;
        o_rf_addr       = '0;
        o_rf_wdata      = '0;
        o_rf_we         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start_dump) begin
                    w_next_state = S_DUMP_RD;
                    w_next_idx   = '0;
                end else if (i_start_load) begin
                    w_next_state = S_LOAD;
                    w_next_idx   = FIRST_LD;
                end
            end

            S_DUMP_RD: begin
                o_rf_addr       = r_idx;
                w_next_out_data = i_rf_rdata;
                w_next_out_idx  = r_idx;
                w_next_state    = S_DUMP_OUT;
            end

            S_DUMP_OUT: begin
                o_rf_addr = r_idx;
                if (i_out_ready) begin
                    if (w_last) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_idx   = r_idx + IDX_ONE;
                        w_next_state = S_DUMP_RD;
                    end
                end
            end

            S_LOAD: begin
                o_rf_addr  = r_idx;
                o_rf_wdata = i_in_data;
                // A write sampled together with reset would commit; suppress it.
                o_rf_we    = i_in_valid && !reset;
                if (i_in_valid) begin
                    if (w_last) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_idx = r_idx + IDX_ONE;
                    end
                end
            end

            S_DONE: begin
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_out_valid = r_out_valid;
    assign o_in_ready  = r_in_ready;
    assign o_out_data  = r_out_data;
    assign o_out_idx   = r_out_idx;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Randomized bench for regfile_debug_port: a bench-side register file, a
// transaction-level reference model and a per-cycle compare process.
module tb_regfile_debug_port;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NUM_REGS = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start_dump = 1'b0;
    logic              start_load = 1'b0;
    logic              busy;
    logic              done;
    logic [4:0]        rf_addr;
    logic [DATA_W-1:0] rf_rdata;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        out_idx;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;

    always #5 clk = ~clk;

    regfile_debug_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start_dump(start_dump),
        .i_start_load(start_load),
        .o_busy      (busy),
        .o_done      (done),
        .o_rf_addr   (rf_addr),
        .i_rf_rdata  (rf_rdata),
        .o_rf_wdata  (rf_wdata),
        .o_rf_we     (rf_we),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_idx   (out_idx),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data)
    );

    // Bench register file: combinational read, write at the rising edge.
    logic [63:0] rf [32];
    logic [63:0] init_vals [32];
    logic        tb_init = 1'b0;
    always @(posedge clk) begin
        if (tb_init) begin
            for (int k = 0; k < 32; k++) rf[k] <= init_vals[k];
        end else if (rf_we) begin
            rf[rf_addr] <= rf_wdata;
        end
    end
    assign rf_rdata = rf[rf_addr];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, expv);
        end
    endtask

    // Reference model: op 0 idle, 1 dump, 2 load, 3 completion cycle.
    int          m_op = 0;
    int          m_cnt = 0;
    int          m_gap = 0;
    logic [63:0] exp_rf [32];

    int          cyc = 0;
    int          start_cyc = -1;
    int          done_cyc = -1;
    int          first_valid_cyc = -1;
    int          n_writes = 0;
    int          n_hs = 0;
    int          n_x0_writes = 0;
    logic [63:0] dq [$];

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_rst = 1'b1;
    logic [63:0] prev_data = '0;
    logic [4:0]  prev_idx = '0;

    // Per-cycle compare against the model, then advance the model.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            chk("we_during_reset", 64'(rf_we), 64'd0);
            m_op = 0;
        end else begin
            if (!prev_rst && prev_valid && !prev_ready) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", out_data, prev_data);
                chk("stall_idx", 64'(out_idx), 64'(prev_idx));
            end
            case (m_op)
                0: begin
                    chk("idle_busy", 64'(busy), 64'd0);
                    chk("idle_done", 64'(done), 64'd0);
                    chk("idle_ovalid", 64'(out_valid), 64'd0);
                    chk("idle_iready", 64'(in_ready), 64'd0);
                    chk("idle_we", 64'(rf_we), 64'd0);
                    chk("idle_addr", 64'(rf_addr), 64'd0);
                end
                1: begin
                    chk("dump_busy", 64'(busy), 64'd1);
                    chk("dump_done", 64'(done), 64'd0);
                    chk("dump_iready", 64'(in_ready), 64'd0);
                    chk("dump_we", 64'(rf_we), 64'd0);
                    chk("dump_ovalid", 64'(out_valid), 64'(m_gap >= 2));
                    if (m_gap == 1) chk("dump_rd_addr", 64'(rf_addr), 64'(m_cnt));
                    if (m_gap >= 2) begin
                        chk("dump_idx", 64'(out_idx), 64'(m_cnt));
                        chk("dump_data", out_data, exp_rf[5'(m_cnt)]);
                    end
                end
                2: begin
                    chk("load_busy", 64'(busy), 64'd1);
                    chk("load_done", 64'(done), 64'd0);
                    chk("load_ovalid", 64'(out_valid), 64'd0);
                    chk("load_iready", 64'(in_ready), 64'd1);
                    chk("load_addr", 64'(rf_addr), 64'(m_cnt + 1));
                    chk("load_we", 64'(rf_we), 64'(in_valid));
                    if (in_valid) chk("load_wdata", rf_wdata, in_data);
                end
                default: begin
                    chk("fin_busy", 64'(busy), 64'd1);
                    chk("fin_done", 64'(done), 64'd1);
                    chk("fin_ovalid", 64'(out_valid), 64'd0);
                    chk("fin_iready", 64'(in_ready), 64'd0);
                    chk("fin_we", 64'(rf_we), 64'd0);
                    chk("fin_addr", 64'(rf_addr), 64'd0);
                end
            endcase
            if (done && done_cyc < 0) done_cyc = cyc;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rf_we) n_writes++;
            if (rf_we && rf_addr == 5'd0) n_x0_writes++;
            if (out_valid && out_ready) dq.push_back(out_data);

            case (m_op)
                0: begin
                    if (start_dump) begin
                        m_op = 1; m_cnt = 0; m_gap = 1; start_cyc = cyc;
                    end else if (start_load) begin
                        m_op = 2; m_cnt = 0; start_cyc = cyc;
                    end
                end
                1: begin
                    if (m_gap >= 2 && out_ready) begin
                        m_cnt++; n_hs++; m_gap = 1;
                        if (m_cnt == NUM_REGS) m_op = 3;
                    end else begin
                        m_gap++;
                    end
                end
                2: begin
                    if (in_valid) begin
                        exp_rf[5'(m_cnt + 1)] = in_data;
                        m_cnt++;
                        if (m_cnt == NUM_REGS - 1) m_op = 3;
                    end
                end
                default: m_op = 0;
            endcase
        end
        prev_rst   = reset;
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
        prev_idx   = out_idx;
        cyc++;
    end

    // Handshake driver: 0 always, 1 every third cycle, 2 random.
    int rdy_mode = 0;
    int vld_mode = 0;
    int data_rand = 0;
    int ph = 0;
    initial forever begin
        @(posedge clk);
        #1;
        ph++;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = (ph % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        case (vld_mode)
            0: in_valid = 1'b1;
            1: in_valid = (ph % 3 == 0);
            default: in_valid = 1'($urandom_range(0, 1));
        endcase
        if (data_rand != 0) in_data = {$urandom, $urandom};
        else in_data = 64'hA5A5_0000_0000_0000 + 64'(m_cnt + 1);
    end

    task automatic preload(input logic [63:0] base, input logic zero_x0);
        for (int k = 0; k < 32; k++) begin
            init_vals[k] = (zero_x0 && k == 0) ? 64'd0 : base + 64'(k);
            exp_rf[k]    = init_vals[k];
        end
        tb_init = 1'b1;
        @(posedge clk); #1;
        tb_init = 1'b0;
    endtask

    task automatic start_op(input logic d, input logic l);
        done_cyc = -1; first_valid_cyc = -1; start_cyc = -1;
        n_writes = 0; n_hs = 0; n_x0_writes = 0;
        dq.delete();
        start_dump = d; start_load = l;
        @(posedge clk); #1;
        start_dump = 1'b0; start_load = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (done_cyc < 0 && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        if (done_cyc < 0) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=no_done required=done within %0d cycles", budget);
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_rf(input string nm);
        for (int k = 0; k < 32; k++) chk(nm, rf[k], exp_rf[k]);
    endtask

    initial begin
        int i;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Full-speed dump of Rk = 0x1000 + k.
        preload(64'h1000, 1'b0);
        rdy_mode = 0;
        start_op(1'b1, 1'b0);
        wait_done(500);
        chk("dump_done_lat", 64'(done_cyc - start_cyc), 64'd65);
        chk("dump_first_valid", 64'(first_valid_cyc - start_cyc), 64'd2);
        chk("dump_hs", 64'(n_hs), 64'd32);
        chk("dump_writes", 64'(n_writes), 64'd0);
        chk("dump_words", 64'(dq.size()), 64'd32);
        chk("dump_w5", dq[5], 64'h1005);
        chk("dump_w31", dq[31], 64'h101F);

        // Dump under 1,0,0 backpressure.
        rdy_mode = 1;
        start_op(1'b1, 1'b0);
        wait_done(1000);
        chk("bp_hs", 64'(n_hs), 64'd32);
        chk("bp_w0", dq[0], 64'h1000);

        // Full-speed load, then random-backpressure dump readback.
        preload(64'hDEAD_0000_0000_0000, 1'b1);
        vld_mode = 0; data_rand = 0;
        start_op(1'b0, 1'b1);
        wait_done(500);
        chk("load_done_lat", 64'(done_cyc - start_cyc), 64'd32);
        chk("load_writes", 64'(n_writes), 64'd31);
        chk("load_x0_writes", 64'(n_x0_writes), 64'd0);
        chk("load_x31", rf[31], 64'hA5A5_0000_0000_001F);
        chk("load_x0", rf[0], 64'd0);
        rdy_mode = 2;
        start_op(1'b1, 1'b0);
        wait_done(2000);
        chk("rb_hs", 64'(n_hs), 64'd32);
        chk("rb_x0", dq[0], 64'd0);
        chk("rb_x17", dq[17], 64'hA5A5_0000_0000_0011);

        // Load with gapped random data.
        vld_mode = 1; data_rand = 1;
        start_op(1'b0, 1'b1);
        wait_done(500);
        chk("gap_writes", 64'(n_writes), 64'd31);
        chk("gap_x0_writes", 64'(n_x0_writes), 64'd0);
        check_rf("gap_rf");

        // Both starts together, plus a stray load request mid-dump.
        vld_mode = 2; rdy_mode = 2;
        start_op(1'b1, 1'b1);
        repeat (10) begin @(posedge clk); #1; end
        start_load = 1'b1;
        @(posedge clk); #1;
        start_load = 1'b0;
        wait_done(2000);
        chk("both_hs", 64'(n_hs), 64'd32);
        chk("both_writes", 64'(n_writes), 64'd0);
        check_rf("both_rf");

        // Reset during the tenth write of a load.
        preload(64'hDEAD_0000_0000_0000, 1'b1);
        vld_mode = 0; data_rand = 0;
        start_op(1'b0, 1'b1);
        i = 0;
        while (m_cnt != 9 && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ld_busy", 64'(busy), 64'd0);
        chk("rst_ld_we", 64'(rf_we), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_ld_writes", 64'(n_writes), 64'd9);
        chk("rst_ld_x9", rf[9], 64'hA5A5_0000_0000_0009);
        chk("rst_ld_x10", rf[10], 64'hDEAD_0000_0000_000A);
        check_rf("rst_ld_rf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
